// File: rtl/i_cache_pkg.sv
// Shared constants for the two-way instruction cache: FSM encoding, kseg1 segment, bus size.
package i_cache_pkg;

    localparam logic [1:0] StIdle     = 2'd0;
    localparam logic [1:0] StRefill   = 2'd1;
    localparam logic [1:0] StUncached = 2'd2;

    localparam logic [2:0] UncachedSeg = 3'b101;
    localparam logic [1:0] SizeWord    = 2'b10;

    function automatic int unsigned line_words(int unsigned offset_width);
        return 32'd1 << (offset_width - 2);
    endfunction

endpackage

// File: rtl/i_cache_way.sv
// One cache way: valid/tag/data arrays with asynchronous read and full-line synchronous write.
module i_cache_way
    import i_cache_pkg::*;
#(
    parameter int unsigned  INDEX_WIDTH  = 7,
    parameter int unsigned  OFFSET_WIDTH = 4,
    localparam int unsigned TAG_WIDTH    = 32 - INDEX_WIDTH - OFFSET_WIDTH,
    localparam int unsigned WORDS        = line_words(OFFSET_WIDTH)
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic [INDEX_WIDTH-1:0] rd_index,
    output logic                   rd_valid,
    output logic [TAG_WIDTH-1:0]   rd_tag,
    output logic [WORDS-1:0][31:0] rd_line,
    input  logic                   wr_en,
    input  logic [INDEX_WIDTH-1:0] wr_index,
    input  logic [TAG_WIDTH-1:0]   wr_tag,
    input  logic [WORDS-1:0][31:0] wr_line
);
    localparam int unsigned SETS = 2 ** INDEX_WIDTH;

    logic [SETS-1:0]        valid_q;
    logic [TAG_WIDTH-1:0]   tag_mem  [SETS];
    logic [WORDS-1:0][31:0] data_mem [SETS];

    always_ff @(posedge clk) begin
        if (rst) begin
            valid_q <= '0;
        end else if (wr_en) begin
            valid_q[wr_index] <= 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (wr_en) begin
            tag_mem[wr_index]  <= wr_tag;
            data_mem[wr_index] <= wr_line;
        end
    end

    assign rd_valid = valid_q[rd_index];
    assign rd_tag   = tag_mem[rd_index];
    assign rd_line  = data_mem[rd_index];

endmodule

// File: rtl/i_cache_2way.sv
// Two-way set-associative instruction cache with LRU replacement, burst line refill
// and an uncached bypass for kseg1 fetches.
module i_cache_2way
    import i_cache_pkg::*;
#(
    parameter int unsigned  INDEX_WIDTH  = 7,
    parameter int unsigned  OFFSET_WIDTH = 4,
    localparam int unsigned TAG_WIDTH    = 32 - INDEX_WIDTH - OFFSET_WIDTH
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        cpu_inst_req,
    input  logic [31:0] cpu_inst_addr,
    output logic [31:0] cpu_inst_rdata,
    output logic        cpu_inst_addr_ok,
    output logic        cpu_inst_data_ok,
    output logic        cache_inst_req,
    output logic        cache_inst_wr,
    output logic [1:0]  cache_inst_size,
    output logic [31:0] cache_inst_addr,
    output logic [31:0] cache_inst_wdata,
    input  logic [31:0] cache_inst_rdata,
    input  logic        cache_inst_addr_ok,
    input  logic        cache_inst_data_ok
);
    localparam int unsigned WORDS  = line_words(OFFSET_WIDTH);
    localparam int unsigned BEAT_W = (WORDS > 1) ? $clog2(WORDS) : 1;
    localparam int unsigned SETS   = 2 ** INDEX_WIDTH;

    logic [1:0]             state_q, state_d;
    logic [BEAT_W-1:0]      beat_q, beat_d;
    logic                   wait_data_q, wait_data_d;
    logic [TAG_WIDTH-1:0]   tag_q, tag_d;
    logic [INDEX_WIDTH-1:0] index_q, index_d;
    logic [31:0]            unc_addr_q, unc_addr_d;
    logic [WORDS-1:0][31:0] line_buf_q, line_buf_d, fill_line;
    logic [SETS-1:0]        lru_q, lru_d;

    logic [TAG_WIDTH-1:0]   cpu_tag;
    logic [INDEX_WIDTH-1:0] cpu_index, rd_index;
    logic [BEAT_W-1:0]      word_sel;
    logic                   uncached, cache_hit, victim, beat_done, last_beat, refill_done;
    logic [1:0]             hit, way_wr;
    logic                   way_valid [2];
    logic [TAG_WIDTH-1:0]   way_tag   [2];
    logic [WORDS-1:0][31:0] way_line  [2];
    logic                   unused_addr_bits;

    assign cpu_tag          = cpu_inst_addr[31 -: TAG_WIDTH];
    assign cpu_index        = cpu_inst_addr[OFFSET_WIDTH +: INDEX_WIDTH];
    assign word_sel         = BEAT_W'((cpu_inst_addr >> 2) & 32'(WORDS - 1));
    assign uncached         = cpu_inst_addr[31:29] == UncachedSeg;
    assign unused_addr_bits = ^cpu_inst_addr[1:0];

    // Outside IDLE the arrays look at the latched set so the victim check sees the refill target.
    assign rd_index = (state_q == StIdle) ? cpu_index : index_q;

    for (genvar w = 0; w < 2; w++) begin : g_way
        i_cache_way #(
            .INDEX_WIDTH (INDEX_WIDTH),
            .OFFSET_WIDTH(OFFSET_WIDTH)
        ) u_way (
            .clk     (clk),
            .rst     (rst),
            .rd_index(rd_index),
            .rd_valid(way_valid[w]),
            .rd_tag  (way_tag[w]),
            .rd_line (way_line[w]),
            .wr_en   (way_wr[w]),
            .wr_index(index_q),
            .wr_tag  (tag_q),
            .wr_line (fill_line)
        );
        assign hit[w]    = way_valid[w] && (way_tag[w] == cpu_tag);
        assign way_wr[w] = refill_done && (victim == 1'(w));
    end

    assign cache_hit   = !rst && (state_q == StIdle) && cpu_inst_req && !uncached && (|hit);
    assign victim      = !way_valid[0] ? 1'b0 : (!way_valid[1] ? 1'b1 : lru_q[index_q]);
    assign beat_done   = !rst && (state_q != StIdle) && (wait_data_q || cache_inst_addr_ok)
                         && cache_inst_data_ok;
    assign last_beat   = beat_q == BEAT_W'(WORDS - 1);
    assign refill_done = beat_done && (state_q == StRefill) && last_beat;

    always_comb begin
        fill_line         = line_buf_q;
        fill_line[beat_q] = cache_inst_rdata;
    end

    always_comb begin
        state_d     = state_q;
        beat_d      = beat_q;
        wait_data_d = wait_data_q;
        tag_d       = tag_q;
        index_d     = index_q;
        unc_addr_d  = unc_addr_q;
        line_buf_d  = line_buf_q;
        lru_d       = lru_q;
        unique case (state_q)
            StIdle: begin
                if (cpu_inst_req) begin
                    if (uncached) begin
                        unc_addr_d  = cpu_inst_addr;
                        wait_data_d = 1'b0;
                        state_d     = StUncached;
                    end else if (|hit) begin
                        lru_d[cpu_index] = hit[0];
                    end else begin
                        tag_d       = cpu_tag;
                        index_d     = cpu_index;
                        beat_d      = '0;
                        wait_data_d = 1'b0;
                        state_d     = StRefill;
                    end
                end
            end
            StRefill: begin
                if (cache_inst_addr_ok) wait_data_d = 1'b1;
                if (beat_done) begin
                    line_buf_d[beat_q] = cache_inst_rdata;
                    wait_data_d        = 1'b0;
                    if (last_beat) begin
                        lru_d[index_q] = ~victim;
                        beat_d         = '0;
                        state_d        = StIdle;
                    end else begin
                        beat_d = beat_q + 1'b1;
                    end
                end
            end
            StUncached: begin
                if (cache_inst_addr_ok) wait_data_d = 1'b1;
                if (beat_done) begin
                    wait_data_d = 1'b0;
                    state_d     = StIdle;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= StIdle;
            beat_q      <= '0;
            wait_data_q <= 1'b0;
            tag_q       <= '0;
            index_q     <= '0;
            unc_addr_q  <= '0;
            line_buf_q  <= '0;
            lru_q       <= '0;
        end else begin
            state_q     <= state_d;
            beat_q      <= beat_d;
            wait_data_q <= wait_data_d;
            tag_q       <= tag_d;
            index_q     <= index_d;
            unc_addr_q  <= unc_addr_d;
            line_buf_q  <= line_buf_d;
            lru_q       <= lru_d;
        end
    end

    always_comb begin
        cpu_inst_rdata = '0;
        if (!rst) begin
            cpu_inst_rdata = (state_q == StUncached) ? cache_inst_rdata
                                                     : way_line[hit[1]][word_sel];
        end
    end

    assign cpu_inst_addr_ok = cache_hit || ((state_q == StUncached) && beat_done);
    assign cpu_inst_data_ok = cpu_inst_addr_ok;

    assign cache_inst_req   = !rst && (state_q != StIdle) && !wait_data_q;
    assign cache_inst_addr  = rst ? 32'd0
                            : (state_q == StUncached) ? unc_addr_q
                            : ({tag_q, index_q, {OFFSET_WIDTH{1'b0}}} | (32'(beat_q) << 2));
    assign cache_inst_wr    = 1'b0;
    assign cache_inst_size  = SizeWord;
    assign cache_inst_wdata = '0;

endmodule

// File: tb/tb_i_cache_2way.sv
// Directed and random bench for i_cache_2way: default geometry plus a 1-word/16-set instance.
module tb_i_cache_2way;

    logic        clk = 1'b0;
    logic        rst;
    logic        req      [2];
    logic [31:0] addr     [2];
    logic [31:0] rdata    [2];
    logic        aok      [2];
    logic        dok      [2];
    logic        mreq     [2];
    logic        mwr      [2];
    logic [1:0]  msize    [2];
    logic [31:0] maddr    [2];
    logic [31:0] mwdata   [2];
    logic [31:0] m_rdata  [2];
    logic        m_aok    [2];
    logic        m_dok    [2];

    int          n_checks = 0;
    int          n_pass   = 0;
    int          addr_dly = 0;
    int          data_dly = 1;
    int          dok_cnt  = 0;
    logic [31:0] log_q [$];
    logic [31:0] exp_q [$];

    always #5 clk = ~clk;

    i_cache_2way u_dut_a (
        .clk(clk), .rst(rst),
        .cpu_inst_req(req[0]), .cpu_inst_addr(addr[0]), .cpu_inst_rdata(rdata[0]),
        .cpu_inst_addr_ok(aok[0]), .cpu_inst_data_ok(dok[0]),
        .cache_inst_req(mreq[0]), .cache_inst_wr(mwr[0]), .cache_inst_size(msize[0]),
        .cache_inst_addr(maddr[0]), .cache_inst_wdata(mwdata[0]),
        .cache_inst_rdata(m_rdata[0]), .cache_inst_addr_ok(m_aok[0]),
        .cache_inst_data_ok(m_dok[0])
    );

    i_cache_2way #(.INDEX_WIDTH(4), .OFFSET_WIDTH(2)) u_dut_b (
        .clk(clk), .rst(rst),
        .cpu_inst_req(req[1]), .cpu_inst_addr(addr[1]), .cpu_inst_rdata(rdata[1]),
        .cpu_inst_addr_ok(aok[1]), .cpu_inst_data_ok(dok[1]),
        .cache_inst_req(mreq[1]), .cache_inst_wr(mwr[1]), .cache_inst_size(msize[1]),
        .cache_inst_addr(maddr[1]), .cache_inst_wdata(mwdata[1]),
        .cache_inst_rdata(m_rdata[1]), .cache_inst_addr_ok(m_aok[1]),
        .cache_inst_data_ok(m_dok[1])
    );

    // Reference memory: the 0x1000 line holds 0x11..0x44, everything else is hashed.
    function automatic logic [31:0] mem_word(input logic [31:0] a);
        if (a[31:4] == 28'h0000100) return 32'h11 * (32'(a[3:2]) + 32'd1);
        return (a * 32'h9E37_79B1) ^ 32'h5A5A_A5A5;
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    endtask

    // Memory responder with programmable addr_ok/data_ok delays, plus protocol checks.
    initial begin
        logic        pending [2];
        logic        stalled [2];
        int          acnt    [2];
        int          dcnt    [2];
        logic [31:0] paddr   [2];
        for (int i = 0; i < 2; i++) begin
            m_aok[i] = 0; m_dok[i] = 0; m_rdata[i] = '0;
            pending[i] = 0; stalled[i] = 0; acnt[i] = 0; dcnt[i] = 0; paddr[i] = '0;
        end
        forever begin
            @(negedge clk);
            #1;
            for (int i = 0; i < 2; i++) begin
                m_aok[i] = 0;
                m_dok[i] = 0;
                if (rst) begin
                    pending[i] = 0; stalled[i] = 0; acnt[i] = 0;
                end else begin
                    if (pending[i]) chk("one_outstanding", 32'(mreq[i]), 32'd0);
                    if (stalled[i]) chk("req_held", 32'(mreq[i]), 32'd1);
                    stalled[i] = 0;
                    if (pending[i]) begin
                        dcnt[i]--;
                        if (dcnt[i] == 0) begin
                            m_dok[i] = 1; m_rdata[i] = mem_word(paddr[i]);
                            pending[i] = 0; dok_cnt++;
                        end
                    end else if (mreq[i]) begin
                        if (acnt[i] >= addr_dly) begin
                            m_aok[i] = 1; acnt[i] = 0; paddr[i] = maddr[i];
                            log_q.push_back(maddr[i]);
                            if (data_dly == 0) begin
                                m_dok[i] = 1; m_rdata[i] = mem_word(maddr[i]); dok_cnt++;
                            end else begin
                                pending[i] = 1; dcnt[i] = data_dly;
                            end
                        end else begin
                            acnt[i]++; stalled[i] = 1;
                        end
                    end
                end
            end
        end
    end

    // Called at a negedge; returns cycles from request to data_ok.
    task automatic fetch(input int i, input logic [31:0] a, input string tag, output int lat);
        logic done = 0;
        exp_q.push_back(mem_word(a));
        req[i] = 1; addr[i] = a; lat = -1;
        for (int c = 0; c < 400; c++) begin
            #2;
            if (dok[i]) begin
                lat = c; done = 1;
                chk({tag, "_data"}, rdata[i], exp_q.pop_front());
                chk({tag, "_addr_ok"}, 32'(aok[i]), 32'd1);
                break;
            end
            @(negedge clk);
        end
        chk({tag, "_done"}, 32'(done), 32'd1);
        if (!done) void'(exp_q.pop_front());
        @(negedge clk);
        req[i] = 0;
    endtask

    task automatic chk_line(input string tag, input logic [31:0] base);
        chk({tag, "_nreq"}, 32'(log_q.size()), 32'd4);
        for (int k = 0; k < 4; k++)
            chk({tag, "_maddr"}, (k < log_q.size()) ? log_q[k] : 32'hDEAD_DEAD, base + 32'(4 * k));
    endtask

    task automatic do_reset();
        rst = 1; req[0] = 0; req[1] = 0;
        @(negedge clk);
        rst = 0;
    endtask

    initial begin
        int lat;
        logic [31:0] a;
        #500000;
        $display("FAIL watchdog: observed timeout expected completion");
        $fatal(1, "watchdog");
        lat = 0; a = 0;
    end

    initial begin
        int lat;
        logic [31:0] a;
        rst = 1;
        for (int i = 0; i < 2; i++) begin req[i] = 1; addr[i] = 32'h0000_1000; end
        repeat (2) @(negedge clk);
        #2;
        for (int i = 0; i < 2; i++) begin
            chk("rst_addr_ok", 32'(aok[i]), 32'd0);
            chk("rst_data_ok", 32'(dok[i]), 32'd0);
            chk("rst_rdata", rdata[i], 32'd0);
            chk("rst_mem_req", 32'(mreq[i]), 32'd0);
            chk("rst_mem_addr", maddr[i], 32'd0);
        end
        chk("const_wr", 32'(mwr[0]), 32'd0);
        chk("const_size", 32'(msize[0]), 32'd2);
        chk("const_wdata", mwdata[0], 32'd0);
        @(negedge clk);
        req[0] = 0; req[1] = 0; rst = 0;
        @(negedge clk);

        // Cold miss then in-line hit
        log_q.delete();
        fetch(0, 32'h0000_1000, "cold", lat);
        chk("cold_latency", 32'(lat), 32'd9);
        chk_line("cold", 32'h0000_1000);
        fetch(0, 32'h0000_100C, "hit44", lat);
        chk("hit44_value", rdata[0] & 32'h0, 32'h0);
        chk("hit44_latency", 32'(lat), 32'd0);
        chk("hit44_nreq", 32'(log_q.size()), 32'd4);

        // Conflict and LRU in set 0
        do_reset();
        fetch(0, 32'h0000_0000, "fill0", lat);
        fetch(0, 32'h0000_0800, "fill1", lat);
        log_q.delete();
        fetch(0, 32'h0000_0000, "hit0", lat);
        chk("hit0_nreq", 32'(log_q.size()), 32'd0);
        fetch(0, 32'h0000_1000, "evict", lat);
        chk_line("evict", 32'h0000_1000);
        log_q.delete();
        fetch(0, 32'h0000_0000, "keep0", lat);
        chk("keep0_nreq", 32'(log_q.size()), 32'd0);
        fetch(0, 32'h0000_0800, "lost1", lat);
        chk_line("lost1", 32'h0000_0800);

        // Uncached bypass
        log_q.delete();
        fetch(0, 32'hBFC0_0000, "unc", lat);
        chk("unc_latency", 32'(lat), 32'd2);
        chk("unc_nreq", 32'(log_q.size()), 32'd1);
        chk("unc_maddr", (log_q.size() > 0) ? log_q[0] : 32'hDEAD_DEAD, 32'hBFC0_0000);
        fetch(0, 32'hBFC0_0000, "unc_again", lat);
        chk("unc_again_nreq", 32'(log_q.size()), 32'd2);

        // Stalled memory
        do_reset();
        addr_dly = 3; data_dly = 5;
        log_q.delete();
        fetch(0, 32'h0000_2000, "stall", lat);
        chk_line("stall", 32'h0000_2000);
        fetch(0, 32'h0000_2008, "stall_hit", lat);
        chk("stall_hit_latency", 32'(lat), 32'd0);
        addr_dly = 0; data_dly = 1;

        // Reset in the middle of a refill
        do_reset();
        dok_cnt = 0;
        req[0] = 1; addr[0] = 32'h0000_3000;
        for (int c = 0; c < 100; c++) begin
            @(negedge clk);
            if (dok_cnt >= 2) break;
        end
        chk("midrst_reached", 32'(dok_cnt >= 2), 32'd1);
        do_reset();
        log_q.delete();
        fetch(0, 32'h0000_3000, "midrst", lat);
        chk_line("midrst", 32'h0000_3000);

        // Random stream on the 1-word, 16-set instance
        do_reset();
        for (int n = 0; n < 80; n++) begin
            addr_dly = $urandom_range(0, 2);
            data_dly = $urandom_range(0, 2);
            if ($urandom_range(0, 7) == 0) a = 32'hBFC0_0000 | (32'($urandom_range(0, 15)) << 2);
            else a = (32'($urandom_range(0, 7)) << 6) | (32'($urandom_range(0, 3)) << 2);
            fetch(1, a, "rand", lat);
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
